sine_checksum_checker: RTL and testbench

Downstream consumer of the CORDIC sine core output stream in the BRAM → CORDIC → display datapath. It accumulates a fixed number of signed sine results, compares the sum against an expected checksum, and raises `success` or `error`. These flags drive the SUCCESS/ERROR letter selection of the seven-segment display logic. It replaces the free-running, uncontrolled summation with a start-triggered, counted, self-terminating check.

---
 rtl/sine_checksum_checker.sv | 177 +++++++++++++++++
 tb/tb_sine_checksum_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sine_checksum_checker.sv
// sine_checksum_checker
// Start-triggered checker for the CORDIC sine stream. After a start pulse it
// sums N_SAMPLES signed sine results (dout_tdata[63:32]) and compares the sum
// with the reference checksum latched at start. The result is shown on the
// success/error flags until the next start.
// Optional feature: define CHECKSUM_TIMEOUT_EN to bound the accumulation phase
// to TIMEOUT_CYCLES cycles. If the budget runs out, the check ends with
// error=1 and timeout=1.
module sine_checksum_checker #(
  parameter int unsigned N_SAMPLES      = 10,
  parameter int unsigned ACC_W          = 40,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK100MHZ,
  input  logic             reset_in,
  input  logic             start,
  input  logic [ACC_W-1:0] expected_sum,
  input  logic             dout_tvalid,
  input  logic [63:0]      dout_tdata,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic             error,
  output logic             timeout,
  output logic [ACC_W-1:0] sum_out,
  output logic [7:0]       count_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Index of the last sample in a check. count_q holds this value while that
  // sample is being accepted.
  localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] exp_q, exp_d;
  logic [7:0]       count_q, count_d;
  logic             success_q, success_d;
  logic             error_q, error_d;

  // Sine sample, sign-extended to the accumulator width
  logic [31:0]      sine_y;
  logic [ACC_W-1:0] sine_ext;

  assign sine_y   = dout_tdata[63:32];
  assign sine_ext = {{(ACC_W - 32){sine_y[31]}}, sine_y};

`ifdef CHECKSUM_TIMEOUT_EN
  // Must be able to hold TIMEOUT_CYCLES-1, the last value of the counter.
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;

  // The low half of the CORDIC word carries the cosine and is not used here.
  logic unused_bits;
  assign unused_bits = ^dout_tdata[31:0];
`else
  // Without the budget, TIMEOUT_CYCLES and the cosine half are unused.
  logic unused_bits;
  assign unused_bits = ^{dout_tdata[31:0], (TIMEOUT_CYCLES != 0)};
`endif

  // Next-state logic: sequencing, accumulation, compare and flag updates
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    exp_d     = exp_q;
    count_d   = count_q;
    success_d = success_q;
    error_d   = error_q;
`ifdef CHECKSUM_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Any tvalid beat in the start cycle is not accumulated.
        if (start) begin
          state_d   = ST_ACCUM;
          acc_d     = '0;
          count_d   = '0;
          exp_d     = expected_sum;
          success_d = 1'b0;
          error_d   = 1'b0;
`ifdef CHECKSUM_TIMEOUT_EN
          timer_d   = '0;
          timeout_d = 1'b0;
`endif
        end
      end

      ST_ACCUM: begin
`ifdef CHECKSUM_TIMEOUT_EN
        timer_d = timer_q + 1'b1;
`endif
        if (dout_tvalid) begin
          acc_d   = acc_q + sine_ext;
          count_d = count_q + 8'd1;
        end
        // If the last sample and the budget expire together, the sample wins.
        if (dout_tvalid && (count_q == LAST_IDX)) begin
          state_d = ST_COMPARE;
        end
`ifdef CHECKSUM_TIMEOUT_EN
        else if (timer_q == TMR_LAST) begin
          state_d   = ST_DONE;
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end

      ST_COMPARE: begin
        success_d = (acc_q == exp_q);
        error_d   = (acc_q != exp_q);
        state_d   = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      exp_q     <= '0;
      count_q   <= '0;
      success_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      exp_q     <= exp_d;
      count_q   <= count_d;
      success_q <= success_d;
      error_q   <= error_d;
    end
  end

`ifdef CHECKSUM_TIMEOUT_EN
  // Registers for the accumulation cycle budget and the timeout flag
  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_COMPARE);
  assign done      = (state_q == ST_DONE);
  assign success   = success_q;
  assign error     = error_q;
  assign sum_out   = acc_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_sine_checksum_checker.sv
// Testbench for sine_checksum_checker (N_SAMPLES=4, ACC_W=40, TIMEOUT_CYCLES=16).
// The checks are driven from a table of vectors, and a scoreboard queue holds
// the expected result of each check.
module tb_sine_checksum_checker;

  localparam int unsigned NS  = 4;
  localparam int unsigned AW  = 40;
  localparam int unsigned TOC = 16;

  logic          CLK100MHZ = 1'b0;
  logic          reset_in;
  logic          start;
  logic [AW-1:0] expected_sum;
  logic          dout_tvalid;
  logic [63:0]   dout_tdata;
  logic          busy, done, success, error, timeout;
  logic [AW-1:0] sum_out;
  logic [7:0]    count_out;

  sine_checksum_checker #(
    .N_SAMPLES(NS),
    .ACC_W(AW),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset_in(reset_in),
    .start(start),
    .expected_sum(expected_sum),
    .dout_tvalid(dout_tvalid),
    .dout_tdata(dout_tdata),
    .busy(busy),
    .done(done),
    .success(success),
    .error(error),
    .timeout(timeout),
    .sum_out(sum_out),
    .count_out(count_out)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic [31:0]   y [4];
    int            gap;
    logic [AW-1:0] exp_sum;
    logic [AW-1:0] want_sum;
    logic          want_success;
  } vec_t;

  typedef struct {
    logic [AW-1:0] sum;
    logic          success;
    logic          error;
    logic [7:0]    count;
  } result_t;

  vec_t    vecs [4];
  result_t sb_q [$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] exp_val);
    expected_sum = exp_val;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] y);
    dout_tvalid = 1'b1;
    dout_tdata  = {y, $urandom()};
    step();
    dout_tvalid = 1'b0;
    dout_tdata  = {32'hDEAD_BEEF, $urandom()};
  endtask

  // Waits (bounded) for done, then compares the outputs with the next scoreboard entry.
  task automatic finish_check(input string tag);
    result_t r;
    int lat = 0;
    check({tag, " compare_state_done"}, done, 1'b0);
    while (!done && lat < 10) begin
      step();
      lat++;
    end
    check({tag, " latency_after_last_beat"}, lat, 1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard: got empty queue, want an entry", tag);
    end else begin
      r = sb_q.pop_front();
      check({tag, " sum_out"}, sum_out, r.sum);
      check({tag, " success"}, success, r.success);
      check({tag, " error"}, error, r.error);
      check({tag, " count_out"}, count_out, r.count);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " timeout"}, timeout, 1'b0);
      $display("check %s: sum=0x%0h success=%0b error=%0b count=%0d", tag, sum_out, success, error, count_out);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    pulse_start(v.exp_sum);
    check({tag, " busy_after_start"}, busy, 1'b1);
    sb_q.push_back('{sum: v.want_sum, success: v.want_success,
                     error: !v.want_success, count: 8'(NS)});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (v.gap) step();
      beat(v.y[i]);
    end
    finish_check(tag);
  endtask

  initial begin
    // Table: 1+2+3+4 = 10; (-1)*4 = -4; -2^31*2+5-5 = -2^32; 1+2+3+5 = 11 vs 10
    vecs[0].y[0] = 32'd1; vecs[0].y[1] = 32'd2; vecs[0].y[2] = 32'd3; vecs[0].y[3] = 32'd4;
    vecs[0].gap = 0; vecs[0].exp_sum = 40'd10; vecs[0].want_sum = 40'd10; vecs[0].want_success = 1'b1;
    for (int i = 0; i < 4; i++) vecs[1].y[i] = 32'hFFFF_FFFF;
    vecs[1].gap = 3; vecs[1].exp_sum = 40'hFF_FFFF_FFFC; vecs[1].want_sum = 40'hFF_FFFF_FFFC; vecs[1].want_success = 1'b1;
    vecs[2].y[0] = 32'h8000_0000; vecs[2].y[1] = 32'h8000_0000; vecs[2].y[2] = 32'd5; vecs[2].y[3] = 32'hFFFF_FFFB;
    vecs[2].gap = 1; vecs[2].exp_sum = 40'hFF_0000_0000; vecs[2].want_sum = 40'hFF_0000_0000; vecs[2].want_success = 1'b1;
    vecs[3].y[0] = 32'd1; vecs[3].y[1] = 32'd2; vecs[3].y[2] = 32'd3; vecs[3].y[3] = 32'd5;
    vecs[3].gap = 0; vecs[3].exp_sum = 40'd10; vecs[3].want_sum = 40'd11; vecs[3].want_success = 1'b0;

    // Reset, asserted together with start: reset must win
    reset_in = 1'b1; start = 1'b1; expected_sum = '0;
    dout_tvalid = 1'b0; dout_tdata = '0;
    step(); step();
    start = 1'b0; reset_in = 1'b0;
    step();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset success", success, 1'b0);
    check("reset error", error, 1'b0);
    check("reset timeout", timeout, 1'b0);
    check("reset sum_out", sum_out, '0);
    check("reset count_out", count_out, 8'd0);
    $display("reset: busy=%0b done=%0b sum=0x%0h", busy, done, sum_out);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Extra beats after the check has finished are ignored
    beat(32'd100); beat(32'd200); step(); beat(32'd300);
    check("extra sum_out", sum_out, 40'd11);
    check("extra count_out", count_out, 8'd4);
    check("extra error held", error, 1'b1);
    check("extra done held", done, 1'b1);
    $display("extra beats: sum=0x%0h count=%0d", sum_out, count_out);

    // New start clears the flags; a start pulse during ACCUM is ignored
    pulse_start(40'd100);
    check("restart success", success, 1'b0);
    check("restart error", error, 1'b0);
    check("restart done", done, 1'b0);
    check("restart sum_out", sum_out, '0);
    check("restart count_out", count_out, 8'd0);
    sb_q.push_back('{sum: 40'd100, success: 1'b1, error: 1'b0, count: 8'd4});
    beat(32'd10); beat(32'd20);
    pulse_start(40'd999);
    check("midstart busy", busy, 1'b1);
    check("midstart count_out", count_out, 8'd2);
    check("midstart sum_out", sum_out, 40'd30);
    beat(32'd30); beat(32'd40);
    finish_check("midstart");

    // start and tvalid in the same cycle: that beat is not accumulated
    expected_sum = 40'd4; start = 1'b1;
    dout_tvalid = 1'b1; dout_tdata = {32'd7, 32'd0};
    step();
    start = 1'b0; dout_tvalid = 1'b0;
    check("startbeat count_out", count_out, 8'd0);
    check("startbeat sum_out", sum_out, '0);
    sb_q.push_back('{sum: 40'd4, success: 1'b1, error: 1'b0, count: 8'd4});
    for (int i = 0; i < 4; i++) beat(32'd1);
    finish_check("startbeat");

    // Reset during ACCUM aborts the check without any flag
    pulse_start(40'd3);
    beat(32'd1); beat(32'd2);
    reset_in = 1'b1; step(); reset_in = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort sum_out", sum_out, '0);
    check("abort count_out", count_out, 8'd0);
    repeat (4) step();
    check("abort done", done, 1'b0);
    check("abort flags", {success, error, timeout}, 3'b000);
    $display("abort: busy=%0b done=%0b sum=0x%0h", busy, done, sum_out);

    // Only three beats: timeout build ends the check, default build waits
    pulse_start(40'd6);
    beat(32'd1); beat(32'd2); beat(32'd3);
`ifdef CHECKSUM_TIMEOUT_EN
    repeat (TOC - 4) step();
    check("timeout early done", done, 1'b0);
    step();
    check("timeout done", done, 1'b1);
    check("timeout error", error, 1'b1);
    check("timeout success", success, 1'b0);
    check("timeout flag", timeout, 1'b1);
    check("timeout count_out", count_out, 8'd3);
`else
    repeat (40) step();
    check("notimeout busy", busy, 1'b1);
    check("notimeout done", done, 1'b0);
    check("notimeout flag", timeout, 1'b0);
    check("notimeout count_out", count_out, 8'd3);
    check("notimeout sum_out", sum_out, 40'd6);
`endif
    $display("short check: busy=%0b done=%0b error=%0b timeout=%0b", busy, done, error, timeout);
    reset_in = 1'b1; step(); reset_in = 1'b0;

    check("scoreboard drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
